// File: rtl/mem_access_unit.sv
// mem_access_unit: pipeline memory stage that issues one data-memory access per instruction,
// stalls upstream until it completes, and qualifies the register writeback.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_res_i,
    input  logic [31:0] rt_data_i,
    input  logic [4:0]  rd_i,
    input  logic        mem_en_i,
    input  logic        mem_r_i,
    input  logic        reg_en_i,
    input  logic        reg_sel_i,
    input  logic        clear_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] wb_data_o,
    output logic        wb_reg_en_o,
    output logic [4:0]  wb_rd_o,
    output logic        misalign_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        kill;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        want;
    logic        candidate;
    logic        access;
    logic        misaligned;
    logic        expire;

    assign want       = mem_en_i | mem_r_i;
    // rst gating keeps stall/misalign low immediately while reset is held
    assign candidate  = rst & (state == IDLE) & want & ~clear_i;
    assign access     = candidate & (alu_res_i[1:0] == 2'b00);
    assign misaligned = candidate & (alu_res_i[1:0] != 2'b00);
    assign expire     = (state == WAIT) & ~dmem_ack_i & (cnt == 5'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            kill    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    kill <= 1'b0;
                    if (access) begin
                        addr_q  <= alu_res_i;
                        wdata_q <= rt_data_i;
                        we_q    <= mem_en_i;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // a flush never cancels the bus cycle, it only suppresses writeback
                    if (clear_i) kill <= 1'b1;
                    if (dmem_ack_i) begin
                        rdata_q <= dmem_rdata_i;
                        state   <= DONE;
                    end else if (expire) begin
                        kill  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    kill  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dmem_req_o   = state == WAIT;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign stall_o      = access | (state == WAIT);
    assign misalign_o   = misaligned;
    assign timeout_o    = expire;
    assign wb_data_o    = (reg_sel_i & mem_r_i & ~mem_en_i) ? rdata_q : alu_res_i;
    assign wb_reg_en_o  = reg_en_i & ~clear_i & ~kill & ~misaligned;
    assign wb_rd_o      = rd_i;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of load, store, misalign, timeout, flush and reset-in-wait.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_res_i = '0;
    logic [31:0] rt_data_i = '0;
    logic [4:0]  rd_i = '0;
    logic        mem_en_i = 1'b0;
    logic        mem_r_i = 1'b0;
    logic        reg_en_i = 1'b0;
    logic        reg_sel_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        stall_o;
    logic [31:0] wb_data_o;
    logic        wb_reg_en_o;
    logic [4:0]  wb_rd_o;
    logic        misalign_o;
    logic        timeout_o;
    int          errors = 0;
    int          checks = 0;
    int          stalls;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .alu_res_i(alu_res_i), .rt_data_i(rt_data_i), .rd_i(rd_i),
        .mem_en_i(mem_en_i), .mem_r_i(mem_r_i), .reg_en_i(reg_en_i), .reg_sel_i(reg_sel_i),
        .clear_i(clear_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .wb_data_o(wb_data_o),
        .wb_reg_en_o(wb_reg_en_o), .wb_rd_o(wb_rd_o), .misalign_o(misalign_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_en_i = 0; mem_r_i = 0; reg_en_i = 0; reg_sel_i = 0; clear_i = 0;
        dmem_ack_i = 0; alu_res_i = '0; rt_data_i = '0;
    endtask

    task automatic load(input logic [31:0] a);
        mem_r_i = 1; mem_en_i = 0; reg_sel_i = 1; reg_en_i = 1; alu_res_i = a; rd_i = 5'd7;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_mis", misalign_o, 0);
        chk("rst_to", timeout_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        @(negedge clk); @(negedge clk);
        rst = 1;

        // load with immediate ack
        @(negedge clk); load(32'h100); #1;
        chk("ld_idle_stall", stall_o, 1);
        chk("ld_idle_req", dmem_req_o, 0);
        @(negedge clk); dmem_ack_i = 1; dmem_rdata_i = 32'hDEADBEEF; #1;
        chk("ld_wait_req", dmem_req_o, 1);
        chk("ld_wait_stall", stall_o, 1);
        chk("ld_wait_we", dmem_we_o, 0);
        chk("ld_wait_addr", dmem_addr_o, 32'h100);
        @(negedge clk); dmem_ack_i = 0; dmem_rdata_i = '0; #1;
        chk("ld_done_stall", stall_o, 0);
        chk("ld_done_req", dmem_req_o, 0);
        chk("ld_done_data", wb_data_o, 32'hDEADBEEF);
        chk("ld_done_wen", wb_reg_en_o, 1);
        chk("ld_done_rd", wb_rd_o, 7);
        @(negedge clk); idle_inputs(); #1;
        chk("ld_after_req", dmem_req_o, 0);

        // store with ack on the fifth WAIT cycle
        @(negedge clk); mem_en_i = 1; alu_res_i = 32'h104; rt_data_i = 32'h12345678; #1;
        stalls = int'(stall_o);
        chk("st_idle_stall", stall_o, 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); alu_res_i = 32'h999; rt_data_i = 32'h0; dmem_ack_i = (i == 5); #1;
            stalls += int'(stall_o);
            chk("st_wait_req", dmem_req_o, 1);
            chk("st_wait_we", dmem_we_o, 1);
            chk("st_wait_addr", dmem_addr_o, 32'h104);
            chk("st_wait_wdata", dmem_wdata_o, 32'h12345678);
        end
        @(negedge clk); dmem_ack_i = 0; #1;
        stalls += int'(stall_o);
        chk("st_done_req", dmem_req_o, 0);
        chk("st_stall_cycles", stalls, 6);
        @(negedge clk); idle_inputs(); #1;

        // misaligned load
        @(negedge clk); load(32'h102); #1;
        chk("mis_pulse", misalign_o, 1);
        chk("mis_stall", stall_o, 0);
        chk("mis_req", dmem_req_o, 0);
        chk("mis_wen", wb_reg_en_o, 0);
        @(negedge clk); idle_inputs(); #1;
        chk("mis_next_req", dmem_req_o, 0);
        chk("mis_next_pulse", misalign_o, 0);

        // timeout: ack never arrives
        @(negedge clk); load(32'h300); #1;
        chk("to_idle_stall", stall_o, 1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); #1;
            chk("to_wait_req", dmem_req_o, 1);
            chk("to_pulse", timeout_o, i == 16);
        end
        @(negedge clk); #1;
        chk("to_done_req", dmem_req_o, 0);
        chk("to_done_pulse", timeout_o, 0);
        chk("to_done_stall", stall_o, 0);
        chk("to_done_wen", wb_reg_en_o, 0);
        @(negedge clk); idle_inputs(); #1;
        chk("to_idle_req", dmem_req_o, 0);

        // flush during WAIT, ack three cycles later
        @(negedge clk); load(32'h400); #1;
        @(negedge clk); clear_i = 1; #1;
        chk("fl_wait1_req", dmem_req_o, 1);
        @(negedge clk); clear_i = 0; #1;
        chk("fl_wait2_req", dmem_req_o, 1);
        @(negedge clk); #1;
        @(negedge clk); dmem_ack_i = 1; dmem_rdata_i = 32'hCAFEF00D; #1;
        chk("fl_wait4_req", dmem_req_o, 1);
        @(negedge clk); dmem_ack_i = 0; #1;
        chk("fl_done_wen", wb_reg_en_o, 0);
        chk("fl_done_data", wb_data_o, 32'hCAFEF00D);
        chk("fl_done_stall", stall_o, 0);
        @(negedge clk); load(32'h404); #1;
        chk("fl_next_stall", stall_o, 1);
        @(negedge clk); dmem_ack_i = 1; dmem_rdata_i = 32'h0BADF00D; #1;
        chk("fl_next_addr", dmem_addr_o, 32'h404);
        @(negedge clk); dmem_ack_i = 0; #1;
        chk("fl_next_wen", wb_reg_en_o, 1);
        chk("fl_next_data", wb_data_o, 32'h0BADF00D);
        @(negedge clk); idle_inputs(); #1;

        // reset asserted mid-WAIT, then a fresh load
        @(negedge clk); load(32'h500); #1;
        @(negedge clk); #1;
        chk("rw_wait_req", dmem_req_o, 1);
        @(negedge clk); #1;
        rst = 0; #1;
        chk("rw_req_drop", dmem_req_o, 0);
        chk("rw_stall_drop", stall_o, 0);
        chk("rw_addr_clr", dmem_addr_o, 0);
        @(negedge clk); rst = 1; load(32'h200); #1;
        chk("rw_new_stall", stall_o, 1);
        @(negedge clk); dmem_ack_i = 1; dmem_rdata_i = 32'h11112222; #1;
        chk("rw_new_req", dmem_req_o, 1);
        chk("rw_new_addr", dmem_addr_o, 32'h200);
        @(negedge clk); dmem_ack_i = 0; #1;
        chk("rw_new_data", wb_data_o, 32'h11112222);
        chk("rw_new_wen", wb_reg_en_o, 1);
        @(negedge clk); idle_inputs(); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
